// File: rtl/qdec_pkg.sv
// -----------------------------------------------------------------------------
// qdec_pkg
// Shared definitions for the quadrature decoder:
//   gray_t       - {A,B} phase encodings
//   qdec_state_t - decode FSM states
//   DIR_UP/DIR_DN- direction levels driven on updown
//   next_up()    - successor of a phase state in the up (A leads B) sequence
// -----------------------------------------------------------------------------
package qdec_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } gray_t;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } qdec_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Up sequence: 00 -> 10 -> 11 -> 01 -> 00
  function automatic gray_t next_up(input gray_t g);
    case (g)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// Two-flop synchroniser followed by a persistence filter. The filtered output
// only follows the synchronised input after it has differed from the current
// filtered value for FILT_LEN consecutive clk edges.
//   clk    - system clock, rising edge
//   clr_n  - asynchronous active-low reset
//   d_in   - raw asynchronous input
//   d_filt - synchronised, debounced output
// -----------------------------------------------------------------------------
module debounce_filter #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d_in,
  output logic d_filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      d_filt  <= 1'b0;
    end else begin
      // synchroniser stage
      sync_p0 <= d_in;
      sync_p1 <= sync_p0;
      // filter stage: the edge that would bring the count to FILT_LEN
      // accepts the new value and restarts the count
      if (sync_p1 == d_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        d_filt <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// Quadrature front end: synchronises and debounces encoder phases A/B, then
// decodes Gray-code transitions into a count-enable pulse and a direction.
//   clk    - system clock, rising edge
//   clr_n  - asynchronous active-low reset
//   a_in   - encoder phase A (asynchronous)
//   b_in   - encoder phase B (asynchronous)
//   step   - one-cycle pulse per legal transition
//   updown - direction of the most recent legal step (1 = up, 0 = down)
//   err    - illegal (two-bit) transition indicator
//   busy   - high while the decoder is still initialising
// Build option: define QDEC_ERR_STICKY_EN to make err a level that sets on the
// first illegal transition and holds until clr_n; otherwise err is a pulse.
// -----------------------------------------------------------------------------
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic updown,
  output logic err,
  output logic busy
);

  // INIT lasts FILT_LEN+3 edges: long enough for a level present at release
  // to reach the filtered outputs and be captured into prev.
  localparam int                INIT_W    = CNT_W + 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(FILT_LEN + 2);

  logic              filt_a;
  logic              filt_b;
  gray_t             cur;
  gray_t             prev;
  qdec_state_t       state;
  qdec_state_t       state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic              step_nxt;
  logic              err_nxt;
  logic              updown_nxt;

  debounce_filter #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) u_filt_a (
    .clk    (clk),
    .clr_n  (clr_n),
    .d_in   (a_in),
    .d_filt (filt_a)
  );

  debounce_filter #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) u_filt_b (
    .clk    (clk),
    .clr_n  (clr_n),
    .d_in   (b_in),
    .d_filt (filt_b)
  );

  assign cur = gray_t'({filt_a, filt_b});

  // state register; prev tracks cur in both states
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= INIT;
      prev     <= S00;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      prev  <= cur;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == INIT_LAST) begin
      state_nxt = TRACK;
    end
  end

  always_comb begin
    step_nxt   = 1'b0;
    updown_nxt = updown;
`ifdef QDEC_ERR_STICKY_EN
    err_nxt    = err;
`else
    err_nxt    = 1'b0;
`endif
    if (state == TRACK && cur != prev) begin
      if (cur == next_up(prev)) begin
        step_nxt   = 1'b1;
        updown_nxt = DIR_UP;
      end else if (prev == next_up(cur)) begin
        step_nxt   = 1'b1;
        updown_nxt = DIR_DN;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // output register stage
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step   <= 1'b0;
      err    <= 1'b0;
      updown <= DIR_UP;
    end else begin
      step   <= step_nxt;
      err    <= err_nxt;
      updown <= updown_nxt;
    end
  end

  assign busy = (state == INIT);

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
// Scoreboard bench for quad_decoder (FILT_LEN=4). Stimulus pushes the expected
// output event (kind, direction, cycle) for each pin change; a monitor on the
// falling clock edge pops and compares whenever step or err appears.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int LAT = 7;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  logic a_in  = 1'b0;
  logic b_in  = 1'b0;
  logic step;
  logic updown;
  logic err;
  logic busy;

  quad_decoder #(.FILT_LEN(4), .CNT_W(8)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .a_in   (a_in),
    .b_in   (b_in),
    .step   (step),
    .updown (updown),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic        dir;
    int unsigned cyc;
  } evt_t;

  evt_t        exp_q[$];
  int unsigned cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: every step/err event must match the head of the queue.
  logic err_d = 1'b0;
  always @(negedge clk) begin
    logic evt_err;
    evt_t e;
`ifdef QDEC_ERR_STICKY_EN
    evt_err = err && !err_d;
`else
    evt_err = err;
`endif
    err_d = err;
    if (step || evt_err) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event: step=%0b err=%0b updown=%0b at cycle %0d, required no event",
                 step, evt_err, updown, cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("event_at_%0d {step,err,updown,cyc}", e.cyc),
              {29'd0, step, evt_err, updown, cyc},
              {29'd0, ~e.is_err, e.is_err, e.dir, e.cyc});
      end
    end
  end

  // Drive pins (called just after a falling edge) and queue the expected event.
  task automatic drive(input logic a, input logic b, input logic is_err,
                       input logic dir, input int hold);
    evt_t e;
    a_in = a;
    b_in = b;
    e.is_err = is_err;
    e.dir    = dir;
    e.cyc    = cyc + LAT;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    // reset with both phases high
    a_in  = 1'b1;
    b_in  = 1'b1;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_step",   step,   1'b0);
    check("reset_err",    err,    1'b0);
    check("reset_updown", updown, 1'b1);
    check("reset_busy",   busy,   1'b1);
    clr_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("busy_after_edge_%0d", i), busy, (i < 7) ? 1'b1 : 1'b0);
    end
    repeat (10) @(negedge clk);

    // re-initialise from 00
    clr_n = 1'b0;
    a_in  = 1'b0;
    b_in  = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    repeat (12) @(negedge clk);
    check("busy_after_init", busy, 1'b0);

    // forward rotation
    drive(1'b1, 1'b0, 1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 10);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 10);

    // reverse rotation
    drive(1'b0, 1'b1, 1'b0, 1'b0, 10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10);

    // 3-cycle glitch on A is rejected
    a_in = 1'b1;
    repeat (3) @(negedge clk);
    a_in = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_filt_a", dut.filt_a, 1'b0);

    // 4-cycle pulse on A is accepted (up), its return low is a down step
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10);

    // illegal 00 -> 11: err, no step, updown holds at 0
    drive(1'b1, 1'b1, 1'b1, 1'b0, 10);
`ifdef QDEC_ERR_STICKY_EN
    check("err_sticky_level", err, 1'b1);
`else
    check("err_pulse_cleared", err, 1'b0);
`endif

    // reset two cycles into a debounce window (11 -> 01)
    a_in = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("midreset_step",   step,   1'b0);
    check("midreset_err",    err,    1'b0);
    check("midreset_updown", updown, 1'b1);
    check("midreset_busy",   busy,   1'b1);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (15) @(negedge clk);
    check("busy_after_midreset", busy, 1'b0);

    // fresh legal transition 01 -> 11 is a down step
    drive(1'b1, 1'b1, 1'b0, 1'b0, 15);

    check("events_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
